// File: rtl/if_ctrl.sv
// Instruction-fetch control: sequences boot hold, hazard stalls, branch redirects
// and halt/resume, driving PC and IF/ID enables plus redirect/stall event counters.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module if_ctrl #(
    parameter int PC_WIDTH         = `PC_WIDTH,
    parameter int BOOT_HOLD        = 2,
    parameter int REDIRECT_BUBBLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                load_use_hazard,
    input  logic                halt_req,
    input  logic                resume,
    output logic                pc_sel,
    output logic [PC_WIDTH-1:0] pc_imm,
    output logic                pc_write,
    output logic                IF_ID_write,
    output logic                IF_flush,
    output logic                halted,
    output logic [15:0]         redirect_cnt,
    output logic [15:0]         stall_cnt
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_RUN,
        S_STALL,
        S_REDIRECT,
        S_HALT
    } state_t;

    state_t      r_state;
    logic [3:0]  r_boot_cnt;
    logic [1:0]  r_bub_cnt;
    logic [15:0] r_redirect_cnt;
    logic [15:0] r_stall_cnt;

    logic w_active;
    logic w_take_br;
    logic w_halt_ev;
    logic w_stall;

    // Branch outranks halt, halt outranks load-use; HALT and BOOT ignore all events.
    assign w_active  = (r_state == S_RUN) || (r_state == S_STALL);
    assign w_take_br = branch_taken && (w_active || (r_state == S_REDIRECT));
    assign w_halt_ev = w_active && !branch_taken && halt_req;
    assign w_stall   = w_active && !branch_taken && load_use_hazard;

    assign redirect_cnt = r_redirect_cnt;
    assign stall_cnt    = r_stall_cnt;

    always_comb begin
        pc_sel      = 1'b0;
        pc_imm      = '0;
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        IF_flush    = 1'b0;
        halted      = 1'b0;
        case (r_state)
            S_BOOT: begin
                IF_flush = 1'b1;
            end
            S_RUN, S_STALL, S_REDIRECT: begin
                if (w_take_br) begin
                    pc_sel      = 1'b1;
                    pc_imm      = branch_target;
                    pc_write    = 1'b1;
                    IF_ID_write = 1'b1;
                    IF_flush    = 1'b1;
                end else if (r_state == S_REDIRECT) begin
                    pc_write    = 1'b1;
                    IF_ID_write = 1'b1;
                    IF_flush    = 1'b1;
                end else if (!w_stall) begin
                    pc_write    = 1'b1;
                    IF_ID_write = 1'b1;
                end
            end
            S_HALT: begin
                IF_flush = 1'b1;
                halted   = 1'b1;
            end
            default: begin
                IF_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_BOOT;
            r_boot_cnt     <= 4'(BOOT_HOLD);
            r_bub_cnt      <= '0;
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_take_br) r_redirect_cnt <= r_redirect_cnt + 16'd1;
            if (w_stall)   r_stall_cnt    <= r_stall_cnt + 16'd1;
            case (r_state)
                S_BOOT: begin
                    if (r_boot_cnt <= 4'd1) begin
                        r_boot_cnt <= '0;
                        r_state    <= S_RUN;
                    end else begin
                        r_boot_cnt <= r_boot_cnt - 4'd1;
                    end
                end
                S_RUN, S_STALL: begin
                    if (w_take_br) begin
                        r_bub_cnt <= 2'(REDIRECT_BUBBLES);
                        r_state   <= S_REDIRECT;
                    end else if (w_halt_ev) begin
                        r_state <= S_HALT;
                    end else if (w_stall) begin
                        r_state <= S_STALL;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_REDIRECT: begin
                    if (w_take_br) begin
                        r_bub_cnt <= 2'(REDIRECT_BUBBLES);
                    end else if (r_bub_cnt <= 2'd1) begin
                        r_bub_cnt <= '0;
                        r_state   <= S_RUN;
                    end else begin
                        r_bub_cnt <= r_bub_cnt - 2'd1;
                    end
                end
                S_HALT: begin
                    if (resume && !halt_req) r_state <= S_RUN;
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_ctrl.sv
// Directed bench for if_ctrl: each cycle pushes the expected outputs to a queue,
// which is popped and compared on the falling edge.
module tb_if_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        load_use_hazard;
    logic        halt_req;
    logic        resume;
    logic        pc_sel;
    logic [31:0] pc_imm;
    logic        pc_write;
    logic        IF_ID_write;
    logic        IF_flush;
    logic        halted;
    logic [15:0] redirect_cnt;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        sel;
        logic [31:0] imm;
        logic        pw;
        logic        iw;
        logic        fl;
        logic        hl;
        logic [15:0] rc;
        logic [15:0] sc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_rc = '0;
    logic [15:0] m_sc = '0;

    if_ctrl #(
        .PC_WIDTH        (32),
        .BOOT_HOLD       (2),
        .REDIRECT_BUBBLES(1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .load_use_hazard(load_use_hazard),
        .halt_req       (halt_req),
        .resume         (resume),
        .pc_sel         (pc_sel),
        .pc_imm         (pc_imm),
        .pc_write       (pc_write),
        .IF_ID_write    (IF_ID_write),
        .IF_flush       (IF_flush),
        .halted         (halted),
        .redirect_cnt   (redirect_cnt),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare at negedge,
    // then advance the counter model for the coming edge.
    task automatic step(input string tag, input logic rst, input logic br, input logic [31:0] tgt,
                        input logic lu, input logic hr, input logic rs,
                        input logic sel, input logic [31:0] imm, input logic pw, input logic iw,
                        input logic fl, input logic hl, input logic inc_r, input logic inc_s);
        exp_t e;
        exp_t p;
        reset           = rst;
        branch_taken    = br;
        branch_target   = tgt;
        load_use_hazard = lu;
        halt_req        = hr;
        resume          = rs;
        e.sel = sel; e.imm = imm; e.pw = pw; e.iw = iw; e.fl = fl; e.hl = hl;
        e.rc  = m_rc; e.sc = m_sc;
        sb.push_back(e);
        @(negedge clk);
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end
        if (sb.size() != 0) begin
            p = sb.pop_front();
            chk({tag, ".pc_sel"},       32'(pc_sel),       32'(p.sel));
            chk({tag, ".pc_imm"},       pc_imm,            p.imm);
            chk({tag, ".pc_write"},     32'(pc_write),     32'(p.pw));
            chk({tag, ".IF_ID_write"},  32'(IF_ID_write),  32'(p.iw));
            chk({tag, ".IF_flush"},     32'(IF_flush),     32'(p.fl));
            chk({tag, ".halted"},       32'(halted),       32'(p.hl));
            chk({tag, ".redirect_cnt"}, 32'(redirect_cnt), 32'(p.rc));
            chk({tag, ".stall_cnt"},    32'(stall_cnt),    32'(p.sc));
        end
        if (rst) begin
            m_rc = '0;
            m_sc = '0;
        end else begin
            if (inc_r) m_rc = m_rc + 16'd1;
            if (inc_s) m_sc = m_sc + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; branch_taken = 1'b0; branch_target = '0;
        load_use_hazard = 1'b0; halt_req = 1'b0; resume = 1'b0;
        @(posedge clk);
        #1;
        //            tag        rst br tgt        lu hr rs   sel imm       pw iw fl hl  ir is
        step("rst_boot",  1, 0, 32'h0,     0, 0, 0,   0, 32'h0,     0, 0, 1, 0,  0, 0);
        step("boot1",     0, 1, 32'h77,    1, 1, 0,   0, 32'h0,     0, 0, 1, 0,  0, 0);
        step("boot2",     0, 0, 32'h0,     0, 0, 0,   0, 32'h0,     0, 0, 1, 0,  0, 0);
        step("run_first", 0, 0, 32'h0,     0, 0, 0,   0, 32'h0,     1, 1, 0, 0,  0, 0);
        step("br_40",     0, 1, 32'h40,    0, 0, 0,   1, 32'h40,    1, 1, 1, 0,  1, 0);
        step("redir_bub", 0, 0, 32'h40,    0, 0, 0,   0, 32'h0,     1, 1, 1, 0,  0, 0);
        step("run_after", 0, 0, 32'h40,    0, 0, 0,   0, 32'h0,     1, 1, 0, 0,  0, 0);
        step("lu1",       0, 0, 32'h0,     1, 0, 0,   0, 32'h0,     0, 0, 0, 0,  0, 1);
        step("lu2",       0, 0, 32'h0,     1, 0, 0,   0, 32'h0,     0, 0, 0, 0,  0, 1);
        step("lu3",       0, 0, 32'h0,     1, 0, 0,   0, 32'h0,     0, 0, 0, 0,  0, 1);
        step("lu_exit",   0, 0, 32'h0,     0, 0, 0,   0, 32'h0,     1, 1, 0, 0,  0, 0);
        step("run_sc3",   0, 0, 32'h0,     0, 0, 0,   0, 32'h0,     1, 1, 0, 0,  0, 0);
        step("br_and_lu", 0, 1, 32'h1234,  1, 0, 0,   1, 32'h1234,  1, 1, 1, 0,  1, 0);
        step("bub2",      0, 0, 32'h1234,  0, 0, 0,   0, 32'h0,     1, 1, 1, 0,  0, 0);
        step("run2",      0, 0, 32'h0,     0, 0, 0,   0, 32'h0,     1, 1, 0, 0,  0, 0);
        step("lu4",       0, 0, 32'h0,     1, 0, 0,   0, 32'h0,     0, 0, 0, 0,  0, 1);
        step("br_stall",  0, 1, 32'h88,    1, 0, 0,   1, 32'h88,    1, 1, 1, 0,  1, 0);
        step("br_redir",  0, 1, 32'h99,    0, 0, 0,   1, 32'h99,    1, 1, 1, 0,  1, 0);
        step("bub3",      0, 0, 32'h99,    0, 0, 0,   0, 32'h0,     1, 1, 1, 0,  0, 0);
        step("run3",      0, 0, 32'h0,     0, 0, 0,   0, 32'h0,     1, 1, 0, 0,  0, 0);
        step("halt_req",  0, 0, 32'h0,     0, 1, 0,   0, 32'h0,     1, 1, 0, 0,  0, 0);
        step("halt_ign",  0, 1, 32'h55,    1, 1, 0,   0, 32'h0,     0, 0, 1, 1,  0, 0);
        step("halt_hold", 0, 0, 32'h0,     0, 1, 1,   0, 32'h0,     0, 0, 1, 1,  0, 0);
        step("resume",    0, 0, 32'h0,     0, 0, 1,   0, 32'h0,     0, 0, 1, 1,  0, 0);
        step("run4",      0, 0, 32'h0,     0, 0, 0,   0, 32'h0,     1, 1, 0, 0,  0, 0);
        step("lu_wrap0",  0, 0, 32'h0,     1, 0, 0,   0, 32'h0,     0, 0, 0, 0,  0, 1);
        // Run the stall counter up to 0xFFFF without per-cycle checks.
        load_use_hazard = 1'b1;
        repeat (32'hFFFF - 32'(m_sc)) @(posedge clk);
        #1;
        m_sc = 16'hFFFF;
        step("sc_ffff",   0, 0, 32'h0,     1, 0, 0,   0, 32'h0,     0, 0, 0, 0,  0, 1);
        step("sc_wrap",   0, 0, 32'h0,     1, 0, 0,   0, 32'h0,     0, 0, 0, 0,  0, 1);
        step("rst_stall", 1, 0, 32'h0,     1, 0, 0,   0, 32'h0,     0, 0, 0, 0,  0, 0);
        step("boot_a",    0, 1, 32'h66,    1, 0, 0,   0, 32'h0,     0, 0, 1, 0,  0, 0);
        step("boot_b",    0, 0, 32'h0,     0, 0, 0,   0, 32'h0,     0, 0, 1, 0,  0, 0);
        step("run5",      0, 0, 32'h0,     0, 0, 0,   0, 32'h0,     1, 1, 0, 0,  0, 0);
        step("br_rst",    0, 1, 32'h10,    0, 0, 0,   1, 32'h10,    1, 1, 1, 0,  1, 0);
        step("rst_redir", 1, 0, 32'h10,    0, 0, 0,   0, 32'h0,     1, 1, 1, 0,  0, 0);
        step("boot_c",    0, 0, 32'h0,     0, 0, 0,   0, 32'h0,     0, 0, 1, 0,  0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
